// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct and aluop constants plus the control FSM state encoding
// shared by mc_control and alu_decoder.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps an R-type funct field to the ALU operation; o_valid flags
// whether the funct is one the datapath supports.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_aluop,
    output logic       o_valid
);
    always_comb begin
        o_valid = 1'b1;
        case (i_funct)
            FN_ADD:  o_aluop = ALU_ADD;
            FN_SUB:  o_aluop = ALU_SUB;
            FN_AND:  o_aluop = ALU_AND;
            FN_OR:   o_aluop = ALU_OR;
            FN_SLT:  o_aluop = ALU_SLT;
            default: begin
                o_aluop = ALU_ADD;
                o_valid = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j).
// Optional macro MC_CONTROL_BNE_EN adds bne through the BRANCH state.
module mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pc_en,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal,
    output logic [3:0] state
);
    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_fn_aluop;
    logic       w_fn_valid;

    alu_decoder u_alu_decoder (
        .i_funct (funct),
        .o_aluop (w_fn_aluop),
        .o_valid (w_fn_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_next;
    end

    // Outputs are gated by rst_n so FETCH strobes stay quiet while reset is held.
    always_comb begin
        w_next   = FETCH;
        aluop    = ALU_ADD;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pc_en    = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        illegal  = 1'b0;
        if (rst_n) begin
            case (r_state)
                FETCH: begin
                    alusrcb = 2'b01;
                    pc_en   = 1'b1;
                    irwrite = 1'b1;
                    w_next  = DECODE;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: w_next = MEMADR;
                        OP_RTYPE:     w_next = EXEC;
                        OP_BEQ:       w_next = BRANCH;
                        OP_ADDI:      w_next = ADDIEX;
                        OP_J:         w_next = JUMP;
`ifdef MC_CONTROL_BNE_EN
                        OP_BNE:       w_next = BRANCH;
`endif
                        default:      illegal = 1'b1;
                    endcase
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    w_next  = (opcode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    iord   = 1'b1;
                    w_next = MEMWB;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                EXEC: begin
                    alusrca = 1'b1;
                    aluop   = w_fn_aluop;
                    illegal = ~w_fn_valid;
                    w_next  = w_fn_valid ? ALUWB : FETCH;
                end
                ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = ALU_SUB;
                    pcsrc   = 2'b01;
`ifdef MC_CONTROL_BNE_EN
                    pc_en   = (opcode == OP_BNE) ? ~zero : zero;
`else
                    pc_en   = zero;
`endif
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    w_next  = ADDIWB;
                end
                ADDIWB: regwrite = 1'b1;
                JUMP: begin
                    pcsrc = 2'b10;
                    pc_en = 1'b1;
                end
                default: w_next = FETCH;
            endcase
        end
    end

    assign state = r_state;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction stream checked cycle by cycle against a
// per-instruction step table model; also exercises asynchronous mid-instruction reset.
module tb_mc_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic [2:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pc_en, iord, memwrite, irwrite, regwrite, regdst, memtoreg, illegal;
    logic [3:0] state;

    int n_chk = 0;
    int n_fail = 0;

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .pc_en(pc_en), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] obs();
        return {state, aluop, alusrca, alusrcb, pcsrc, pc_en, iord, memwrite,
                irwrite, regwrite, regdst, memtoreg, illegal};
    endfunction

    function automatic bit bne_on();
`ifdef MC_CONTROL_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        return (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
            || (op == 6'b000101 && bne_on());
    endfunction

    // Cycles each instruction occupies, including the aborted forms.
    function automatic int cpi(input logic [5:0] op, input logic [5:0] fn);
        if (!op_ok(op))       return 2;
        if (op == 6'b100011)  return 5;
        if (op == 6'b101011)  return 4;
        if (op == 6'b001000)  return 4;
        if (op == 6'b000000)  return fn_ok(fn) ? 4 : 3;
        return 3;
    endfunction

    // Expected outputs at step k of an instruction.
    function automatic logic [19:0] exp_out(input int k, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z);
        state_t     s  = FETCH;
        logic [2:0] a  = 3'b010;
        logic       sa = 0, pe = 0, io = 0, mw = 0, iw = 0, rw = 0, rd = 0, mt = 0, il = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        if (k == 0) begin
            sb = 2'b01; pe = 1; iw = 1;
        end else if (k == 1) begin
            s = DECODE; sb = 2'b11; il = !op_ok(op);
        end else if (op == 6'b100011 || op == 6'b101011) begin
            if (k == 2) begin s = MEMADR; sa = 1; sb = 2'b10; end
            else if (op == 6'b101011) begin s = MEMWR; io = 1; mw = 1; end
            else if (k == 3) begin s = MEMRD; io = 1; end
            else begin s = MEMWB; rw = 1; mt = 1; end
        end else if (op == 6'b000000) begin
            if (k == 2) begin
                s = EXEC; sa = 1;
                case (fn)
                    6'b100010: a = 3'b110;
                    6'b100100: a = 3'b000;
                    6'b100101: a = 3'b001;
                    6'b101010: a = 3'b111;
                    default:   a = 3'b010;
                endcase
                il = !fn_ok(fn);
            end else begin
                s = ALUWB; rw = 1; rd = 1;
            end
        end else if (op == 6'b000100 || op == 6'b000101) begin
            s = BRANCH; sa = 1; a = 3'b110; ps = 2'b01;
            pe = (op == 6'b000101) ? ~z : z;
        end else if (op == 6'b001000) begin
            if (k == 2) begin s = ADDIEX; sa = 1; sb = 2'b10; end
            else begin s = ADDIWB; rw = 1; end
        end else begin
            s = JUMP; ps = 2'b10; pe = 1;
        end
        return {4'(s), a, sa, sb, ps, pe, io, mw, iw, rw, rd, mt, il};
    endfunction

    localparam logic [19:0] RST_VEC = {4'd0, 3'b010, 13'd0};

    // Entered at posedge+1 with the DUT in FETCH. zsel<0 randomizes zero each cycle.
    // rst_at>=0 asserts reset partway through that step and abandons the instruction.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int zsel, input int rst_at);
        int n = cpi(op, fn);
        for (int k = 0; k < n; k++) begin
            opcode = op;
            funct  = fn;
            zero   = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            if (k == rst_at) begin
                #1 rst_n = 1'b0;
                #1 check({tag, "_rst_async"}, obs(), RST_VEC);
                @(posedge clk);
                #1 check({tag, "_rst_hold"}, obs(), RST_VEC);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            check($sformatf("%s_k%0d", tag, k), obs(), exp_out(k, op, fn, zero));
            check({tag, "_excl"}, 20'(memwrite & regwrite), 20'd0);
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] op_pool [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                               6'b000101, 6'b001000, 6'b000010, 6'b111111};
    logic [5:0] fn_pool [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    initial begin
        #2 check("reset_low", obs(), RST_VEC);
        @(posedge clk);
        #1 check("reset_low_edge", obs(), RST_VEC);
        rst_n = 1'b1;
        run_instr("lw",       6'b100011, 6'b0, -1, -1);
        run_instr("sw",       6'b101011, 6'b0, -1, -1);
        run_instr("r_sub",    6'b000000, 6'b100010, -1, -1);
        run_instr("r_slt",    6'b000000, 6'b101010, -1, -1);
        run_instr("r_bad",    6'b000000, 6'b111000, -1, -1);
        run_instr("beq_z1",   6'b000100, 6'b0, 1, -1);
        run_instr("beq_z0",   6'b000100, 6'b0, 0, -1);
        run_instr("addi",     6'b001000, 6'b0, -1, -1);
        run_instr("j",        6'b000010, 6'b0, -1, -1);
        run_instr("ill",      6'b111111, 6'b0, -1, -1);
        run_instr("bne_z0",   6'b000101, 6'b0, 0, -1);
        run_instr("sw_rst",   6'b101011, 6'b0, -1, 3);
        run_instr("after_rst", 6'b100011, 6'b0, -1, -1);
        run_instr("lw_rst",   6'b100011, 6'b0, -1, 4);
        run_instr("r_rst",    6'b000000, 6'b100000, -1, 3);
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 8)];
            logic [5:0] fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
            int ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, cpi(op, fn) - 1) : -1;
            run_instr($sformatf("rnd%0d", i), op, fn, -1, ra);
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
